// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame state encoding and data width.
package uart_pkg;
   localparam int UART_DATA_BITS = 8;
   typedef enum logic [3:0] {
      Idle, Start, Bit0, Bit1, Bit2, Bit3, Bit4, Bit5, Bit6, Bit7, Stop
   } eUartState;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
   parameter bit pRstVal = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta, r_sync;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_meta <= pRstVal;
         r_sync <= pRstVal;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver with majority-vote sampling,
// a single-entry holding register and valid/ready delivery.
module uart_rx
   import uart_pkg::*;
#(
   parameter int pTicksPerBaud = 16,
   parameter bit pInvertData   = 1'b0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_rx,
   output logic [UART_DATA_BITS-1:0] o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_frame_err,
   output logic                      o_overrun
);
   localparam int CW = (pTicksPerBaud < 8) ? 3 : $clog2(pTicksPerBaud);
   localparam logic [CW-1:0] MID0 = CW'(pTicksPerBaud / 2 - 1);
   localparam logic [CW-1:0] MID  = CW'(pTicksPerBaud / 2);
   localparam logic [CW-1:0] MID1 = CW'(pTicksPerBaud / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(pTicksPerBaud - 1);
   localparam logic [UART_DATA_BITS-1:0] INV = pInvertData ? '1 : '0;

   if (pTicksPerBaud < 8) begin : g_bad_baud
      $error("uart_rx: pTicksPerBaud must be >= 8");
   end

   eUartState                 r_state, w_state_nx;
   logic [CW-1:0]             r_cnt, w_cnt_nx;
   logic [UART_DATA_BITS-1:0] r_shift, w_shift_nx, r_data, w_data_nx;
   logic [1:0]                r_samp, w_samp_nx;
   logic                      r_armed, w_armed_nx;
   logic                      r_valid, w_valid_nx, r_ferr, w_ferr_nx, r_ovr, w_ovr_nx;
   logic                      w_rx_s, w_maj, w_dec, w_wrap;

   sync_2ff #(.pRstVal(1'b1)) u_sync (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_rx), .o_q(w_rx_s)
   );

   assign w_maj  = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
   assign w_dec  = r_cnt == MID1;
   assign w_wrap = r_cnt == LAST;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= Idle;
         r_cnt   <= '0;
         r_shift <= '0;
         r_samp  <= '0;
         r_armed <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_shift <= w_shift_nx;
         r_samp  <= w_samp_nx;
         r_armed <= w_armed_nx;
         r_data  <= w_data_nx;
         r_valid <= w_valid_nx;
         r_ferr  <= w_ferr_nx;
         r_ovr   <= w_ovr_nx;
      end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = w_wrap ? '0 : r_cnt + CW'(1);
      w_shift_nx = r_shift;
      w_samp_nx  = r_samp;
      w_armed_nx = r_armed | w_rx_s;
      w_data_nx  = r_data;
      w_valid_nx = r_valid & ~i_ready;
      w_ferr_nx  = 1'b0;
      w_ovr_nx   = 1'b0;
      if (r_cnt == MID0) w_samp_nx[0] = w_rx_s;
      if (r_cnt == MID) w_samp_nx[1] = w_rx_s;
      case (r_state)
         Idle: begin
            w_cnt_nx = '0;
            if (r_armed && !w_rx_s) w_state_nx = Start;
         end
         Start:
            if (w_dec && w_maj) begin
               w_state_nx = Idle;
               w_armed_nx = 1'b0;
            end else if (w_wrap) w_state_nx = Bit0;
         // Leave at the stop decision so a back-to-back start edge is not missed
         Stop:
            if (w_dec) begin
               w_state_nx = Idle;
               w_armed_nx = 1'b0;
               if (!w_maj) w_ferr_nx = 1'b1;
               else if (!r_valid || i_ready) begin
                  w_data_nx  = r_shift ^ INV;
                  w_valid_nx = 1'b1;
               end else w_ovr_nx = 1'b1;
            end
         default: begin
            if (w_dec) w_shift_nx = {w_maj, r_shift[UART_DATA_BITS-1:1]};
            if (w_wrap) w_state_nx = eUartState'(r_state + 4'd1);
         end
      endcase
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_ferr;
   assign o_overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, overrun;

   int n_pass = 0, n_total = 0;
   int n_ferr = 0, n_ovr = 0, n_vcyc = 0;
   logic [7:0] sb[$];

   uart_rx #(.pTicksPerBaud(16), .pInvertData(1'b0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_data(data), .o_valid(valid),
      .i_ready(ready), .o_frame_err(frame_err), .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit glitch);
      for (int i = 0; i < 10; i++)
         for (int c = 0; c < 16; c++) begin
            logic v;
            v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            rx = (glitch && i > 0 && i < 9 && c == 9) ? ~v : v;
            tick(1);
         end
   endtask

   always @(negedge clk) begin
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (valid) n_vcyc++;
      if (frame_err || overrun) chk("pulse_exclusive", {31'd0, frame_err & overrun}, 0);
      if (valid && ready) begin
         if (sb.size() == 0) chk("sb_unexpected", {24'd0, data}, 32'hFFFF_FFFF);
         else chk("sb_data", {24'd0, data}, {24'd0, sb.pop_front()});
      end
   end

   initial begin
      int f0, o0, v0;
      tick(3);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_data", {24'd0, data}, 0);
      chk("rst_ferr", {31'd0, frame_err}, 0);
      chk("rst_ovr", {31'd0, overrun}, 0);
      rst_n = 1'b1;
      tick(4);
      // 1: single byte, consumer ready
      f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc;
      sb.push_back(8'hA5);
      send(8'hA5, 1'b0);
      tick(8);
      chk("t1_valid_cycles", n_vcyc - v0, 1);
      chk("t1_ferr", n_ferr - f0, 0);
      chk("t1_ovr", n_ovr - o0, 0);
      // 2: back-to-back with stalled consumer
      ready = 1'b0;
      o0 = n_ovr;
      sb.push_back(8'h3C);
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b0);
      tick(8);
      chk("t2_data_kept", {24'd0, data}, 8'h3C);
      chk("t2_valid_held", {31'd0, valid}, 1);
      chk("t2_ovr_once", n_ovr - o0, 1);
      ready = 1'b1;
      tick(1);
      chk("t2_valid_drop", {31'd0, valid}, 0);
      chk("t2_data_stable", {24'd0, data}, 8'h3C);
      // 3: short low glitch in Idle
      f0 = n_ferr; v0 = n_vcyc;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(40);
      chk("t3_no_valid", n_vcyc - v0, 0);
      chk("t3_no_ferr", n_ferr - f0, 0);
      sb.push_back(8'h00);
      send(8'h00, 1'b0);
      tick(8);
      chk("t3_byte", n_vcyc - v0, 1);
      // 4: break condition
      f0 = n_ferr; v0 = n_vcyc;
      rx = 1'b0;
      tick(30 * 16);
      rx = 1'b1;
      tick(32);
      chk("t4_one_ferr", n_ferr - f0, 1);
      chk("t4_no_valid", n_vcyc - v0, 0);
      sb.push_back(8'h55);
      send(8'h55, 1'b0);
      tick(8);
      chk("t4_byte", n_vcyc - v0, 1);
      // 5: mid-bit glitches rejected by the vote
      v0 = n_vcyc;
      sb.push_back(8'hF0);
      send(8'hF0, 1'b1);
      tick(8);
      chk("t5_byte", n_vcyc - v0, 1);
      chk("t5_data", {24'd0, data}, 8'hF0);
      // 6: reset mid-frame while a byte is held
      ready = 1'b0;
      send(8'h77, 1'b0);
      tick(8);
      chk("t6_held", {31'd0, valid}, 1);
      for (int i = 0; i < 4 * 16 + 8; i++) begin
         rx = (i < 16) ? 1'b0 : 1'b1;
         tick(1);
      end
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, valid}, 0);
      chk("t6_rst_data", {24'd0, data}, 0);
      rx = 1'b1;
      tick(3);
      rst_n = 1'b1;
      ready = 1'b1;
      tick(4);
      f0 = n_ferr; o0 = n_ovr; v0 = n_vcyc;
      sb.push_back(8'h81);
      send(8'h81, 1'b0);
      tick(8);
      chk("t6_byte", n_vcyc - v0, 1);
      chk("t6_no_ferr", n_ferr - f0, 0);
      chk("t6_no_ovr", n_ovr - o0, 0);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
